// File: rtl/uart_core_txrx.sv
// -----------------------------------------------------------------------------
// uart_core_txrx
//
// Serial engine under the memory-mapped UART peripheral. It turns bytes into
// asynchronous frames on uart_txd and recovers bytes from uart_rxd. Timing
// comes from 16x oversampling of the line rate, derived from a single clock.
//
// Default frame is 8N1. Define UART_PARITY_EN to add an even parity bit
// between the data and the stop bit, in both directions.
//
// Parameters
//   freq_hz   system clock frequency in Hz
//   baud      line rate in bit/s
//
// Ports
//   clk        system clock; all logic on the rising edge
//   rst        synchronous reset, active high
//   uart_rxd   serial input, asynchronous to clk, idles high
//   uart_txd   serial output, idles high
//   tx_data    byte to send, captured on the tx_wr rising edge
//   tx_wr      rising edge starts a frame; a held level does nothing more
//   tx_busy    high while a frame is being sent
//   rx_data    last received byte
//   rx_avail   a byte is waiting in rx_data
//   rx_error   framing, overrun or parity error since the last ack
//   rx_ack     rising edge clears rx_avail and rx_error
// -----------------------------------------------------------------------------
module uart_core_txrx #(
  parameter int freq_hz = 25000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack
);

  // Clocks per oversampling tick, rounded to nearest, never below one.
  localparam int DIV_RAW  = (freq_hz + 8 * baud) / (16 * baud);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int BIT_W    = $clog2(BIT_CLKS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Free-running oversampling tick and input conditioning
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tx_wr_q;
  logic             rx_ack_q;
  logic             rxd_s1;
  logic             rxd_s2;
  logic             tx_wr_edge;
  logic             rx_ack_edge;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      tx_wr_q  <= 1'b0;
      rx_ack_q <= 1'b0;
      // Synchroniser comes out of reset at the idle level so no false start.
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
    end else begin
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      tx_wr_q  <= tx_wr;
      rx_ack_q <= rx_ack;
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
    end
  end

  assign tick        = (div_cnt == DIV_LAST);
  assign tx_wr_edge  = tx_wr & ~tx_wr_q;
  assign rx_ack_edge = rx_ack & ~rx_ack_q;

  // ---------------------------------------------------------------------------
  // Transmitter
  // Bit timing is measured from the frame start rather than from the shared
  // tick, so every transmitted bit is exactly 16*DIV clocks long regardless
  // of where the divider happened to be when tx_wr arrived.
  // ---------------------------------------------------------------------------
  tx_state_t        tx_state;
  logic [7:0]       tx_shift;
  logic [2:0]       tx_idx;
  logic [BIT_W-1:0] tx_cnt;
`ifdef UART_PARITY_EN
  logic             tx_par;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_cnt   <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr_edge) begin
            tx_shift <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_data;
`endif
            uart_txd <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        default: begin
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + BIT_W'(1);
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: begin
                uart_txd <= tx_shift[0];
                tx_idx   <= '0;
                tx_state <= TX_DATA;
              end
              TX_DATA: begin
                if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  uart_txd <= tx_par;
                  tx_state <= TX_PARITY;
`else
                  uart_txd <= 1'b1;
                  tx_state <= TX_STOP;
`endif
                end else begin
                  // Bit 0 of the shift register is always the bit on the line.
                  uart_txd <= tx_shift[1];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_idx   <= tx_idx + 3'd1;
                end
              end
`ifdef UART_PARITY_EN
              TX_PARITY: begin
                uart_txd <= 1'b1;
                tx_state <= TX_STOP;
              end
`endif
              TX_STOP: begin
                tx_busy  <= 1'b0;
                tx_state <= TX_IDLE;
              end
              default: begin
                uart_txd <= 1'b1;
                tx_busy  <= 1'b0;
                tx_state <= TX_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // A low seen on a tick opens a frame; eight ticks later the start bit is
  // re-checked near its centre, and every later sample is 16 ticks apart so
  // it also lands mid-bit.
  // ---------------------------------------------------------------------------
  rx_state_t  rx_state;
  logic [3:0] rx_tick_cnt;
  logic [2:0] rx_idx;
  logic [7:0] rx_shift;
`ifdef UART_PARITY_EN
  logic       rx_par_bad;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_tick_cnt <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_avail    <= 1'b0;
      rx_error    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad  <= 1'b0;
`endif
    end else begin
      // NOTE: the ack clear is written first so that a byte completing in the
      // same clock overrides it; the last non-blocking assignment wins.
      if (rx_ack_edge) begin
        rx_avail <= 1'b0;
        rx_error <= 1'b0;
      end

      case (rx_state)
        RX_IDLE: begin
          if (tick && !rxd_s2) begin
            rx_tick_cnt <= '0;
            rx_state    <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick_cnt == 4'd7) begin
              rx_tick_cnt <= '0;
              rx_idx      <= '0;
              // A line back high by mid start bit was only a glitch.
              rx_state    <= rxd_s2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              rx_shift <= {rxd_s2, rx_shift[7:1]};
              rx_idx   <= rx_idx + 3'd1;
              if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                rx_state <= RX_PARITY;
`else
                rx_state <= RX_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              rx_par_bad <= (rxd_s2 != ^rx_shift);
              rx_state   <= RX_STOP;
            end
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              rx_data <= rx_shift;
              if (rxd_s2) begin
                // Good stop bit: a byte already waiting means overrun.
                rx_avail <= 1'b1;
                if (rx_avail) rx_error <= 1'b1;
              end else begin
                rx_error <= 1'b1;
              end
`ifdef UART_PARITY_EN
              if (rx_par_bad) rx_error <= 1'b1;
`endif
              rx_state <= RX_IDLE;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_txrx.sv
// -----------------------------------------------------------------------------
// tb_uart_core_txrx
//
// Self-checking bench for uart_core_txrx at its default rates (DIV = 14,
// one bit = 224 clocks). Transmitted frames are compared bit by bit against
// a frame built from the byte; received bytes are driven as ideal frames
// and the status flags are compared against a directed table and a small
// behavioural model of the flag rules.
// -----------------------------------------------------------------------------
module tb_uart_core_txrx;

  localparam int FREQ = 25000000;
  localparam int BAUD = 115200;
  localparam int DIV  = (FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int BIT  = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_ack;

  int n_vec = 0;
  int n_bad = 0;

`ifdef UART_PARITY_EN
  logic rx_par_flip = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       ack_first;
    logic [7:0] exp_data;
    logic       exp_avail;
    logic       exp_err;
  } rx_vec_t;

  rx_vec_t vecs[7];

  uart_core_txrx #(.freq_hz(FREQ), .baud(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_error (rx_error),
    .rx_ack   (rx_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    rx_ack = 1'b1;
    repeat (2) @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  // Drives one ideal frame on uart_rxd, followed by one bit time of idle.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_PARITY_EN
    bits.push_back((^d) ^ rx_par_flip);
`endif
    bits.push_back(stop_bit);
    foreach (bits[i]) begin
      uart_rxd = bits[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Starts a frame, records uart_txd for every clock tx_busy is high, and
  // checks the busy length and the centre of every bit against the frame
  // expected for byte d. At sample index inj a second tx_wr edge with other
  // data is raised while busy (inj < 0 disables it).
  task automatic send_tx(input logic [7:0] d, input int inj,
                         output int lead_zeros);
    logic fb[$];
    logic samp[$];
    int   n;
    int   idx;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
`ifdef UART_PARITY_EN
    fb.push_back(^d);
`endif
    fb.push_back(1'b1);

    @(negedge clk);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    n = 0;
    while (tx_busy !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("tx_busy_rise", {31'b0, tx_busy}, 32'd1);

    n = 0;
    while (tx_busy === 1'b1 && n < 4000) begin
      samp.push_back(uart_txd);
      if (n == 2) tx_wr = 1'b0;
      if (n == inj) begin
        tx_data = ~d;
        tx_wr   = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check("tx_busy_len", n, fb.size() * BIT);

    for (int i = 0; i < fb.size(); i++) begin
      idx = i * BIT + BIT / 2;
      check($sformatf("tx_%02h_bit%0d", d, i),
            {31'b0, (idx < samp.size()) ? samp[idx] : 1'bx},
            {31'b0, fb[i]});
    end

    lead_zeros = 0;
    while (lead_zeros < samp.size() && samp[lead_zeros] === 1'b0)
      lead_zeros++;
  endtask

  initial begin
    int         lz;
    logic [7:0] d;
    logic       stop_bit;
    logic [7:0] m_data;
    logic       m_avail;
    logic       m_err;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

    rst      = 1'b1;
    uart_rxd = 1'b1;
    tx_data  = 8'h00;
    tx_wr    = 1'b0;
    rx_ack   = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_txd",      {31'b0, uart_txd}, 32'd1);
    check("rst_tx_busy",  {31'b0, tx_busy},  32'd0);
    check("rst_rx_data",  {24'b0, rx_data},  32'd0);
    check("rst_rx_avail", {31'b0, rx_avail}, 32'd0);
    check("rst_rx_error", {31'b0, rx_error}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Transmit 0xA5: start bit exactly one bit time, then the data pattern
    send_tx(8'hA5, -1, lz);
    check("tx_start_len", lz, BIT);

    // Directed receive table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ack_first) begin
        ack_pulse();
        check($sformatf("vec%0d_ack_avail", i), {31'b0, rx_avail}, 32'd0);
        check($sformatf("vec%0d_ack_error", i), {31'b0, rx_error}, 32'd0);
      end
      send_rx(vecs[i].data, vecs[i].stop_bit);
      check($sformatf("vec%0d_rx_data", i),  {24'b0, rx_data},  {24'b0, vecs[i].exp_data});
      check($sformatf("vec%0d_rx_avail", i), {31'b0, rx_avail}, {31'b0, vecs[i].exp_avail});
      check($sformatf("vec%0d_rx_error", i), {31'b0, rx_error}, {31'b0, vecs[i].exp_err});
    end

    // Short low pulse on the line changes nothing, then a real byte lands
    uart_rxd = 1'b0;
    repeat (42) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_rx_data",  {24'b0, rx_data},  {24'b0, vecs[6].exp_data});
    check("glitch_rx_avail", {31'b0, rx_avail}, {31'b0, vecs[6].exp_avail});
    check("glitch_rx_error", {31'b0, rx_error}, {31'b0, vecs[6].exp_err});
    ack_pulse();
    send_rx(8'h81, 1'b1);
    check("post_glitch_rx_data",  {24'b0, rx_data},  32'h81);
    check("post_glitch_rx_avail", {31'b0, rx_avail}, 32'd1);
    check("post_glitch_rx_error", {31'b0, rx_error}, 32'd0);

    // Random receive traffic against the flag model
    ack_pulse();
    m_data  = 8'h81;
    m_avail = 1'b0;
    m_err   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        m_avail = 1'b0;
        m_err   = 1'b0;
      end
      d        = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      send_rx(d, stop_bit);
      m_data = d;
      if (!stop_bit)    m_err   = 1'b1;
      else if (m_avail) m_err   = 1'b1;
      else              m_avail = 1'b1;
      check($sformatf("rand%0d_rx_data", k),  {24'b0, rx_data},  {24'b0, m_data});
      check($sformatf("rand%0d_rx_avail", k), {31'b0, rx_avail}, {31'b0, m_avail});
      check($sformatf("rand%0d_rx_error", k), {31'b0, rx_error}, {31'b0, m_err});
    end

    // Random transmit bytes
    for (int k = 0; k < 3; k++) send_tx(8'($urandom), -1, lz);

    // A second tx_wr edge mid-frame is ignored, and the level it leaves
    // held high afterwards does not start another frame
    send_tx(8'h5A, 900, lz);
    repeat (300) @(negedge clk);
    check("held_wr_busy", {31'b0, tx_busy},  32'd0);
    check("held_wr_txd",  {31'b0, uart_txd}, 32'd1);
    tx_wr = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during data bit 4 of a frame
    tx_data = 8'h0F;
    tx_wr   = 1'b1;
    repeat (5 * BIT + 100) @(negedge clk);
    check("pre_rst_busy", {31'b0, tx_busy},  32'd1);
    check("pre_rst_txd",  {31'b0, uart_txd}, 32'd0);
    rst   = 1'b1;
    tx_wr = 1'b0;
    @(negedge clk);
    check("mid_rst_txd",      {31'b0, uart_txd}, 32'd1);
    check("mid_rst_busy",     {31'b0, tx_busy},  32'd0);
    check("mid_rst_rx_avail", {31'b0, rx_avail}, 32'd0);
    check("mid_rst_rx_data",  {24'b0, rx_data},  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_tx(8'h0F, -1, lz);

`ifdef UART_PARITY_EN
    // Bad parity is flagged while the byte is still delivered
    rx_par_flip = 1'b1;
    send_rx(8'h07, 1'b1);
    rx_par_flip = 1'b0;
    check("par_rx_data",  {24'b0, rx_data},  32'h07);
    check("par_rx_avail", {31'b0, rx_avail}, 32'd1);
    check("par_rx_error", {31'b0, rx_error}, 32'd1);
    send_tx(8'h07, -1, lz);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
